dram_miss_sequencer: RTL and testbench
======================================

DRAM_MISS_SEQUENCER -- requirements
Module: dram_miss_sequencer

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2: request queue entries, legal values 2 or 4.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: WAIT_ACK cycles before err_timeout sets.
REQ-003 main_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 main_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  cache miss request present.
REQ-006 req_ready  out  1  queue can accept; equals "queue not full".
REQ-007 req_addr_read  in  22  line address to fetch.
REQ-008 req_addr_write_upper  in  13  victim line address bits [21:9]; victim bits [8:0] equal req_addr_read[8:0].
REQ-009 req_dirty  in  1  victim is dirty and must be written back.
REQ-010 req_lane_write  in  128  victim line data.
REQ-011 rsp_valid  out  1  fetched line available.
REQ-012 rsp_ready  in  1  cache consumes response.
REQ-013 rsp_addr  out  22  address of the returned line.
REQ-014 rsp_lane  out  128  returned line data.
REQ-015 addr_req_read_dram_side_dram  out  13  head read address [21:9].
REQ-016 addr_req_write_dram_side_dram  out  13  head victim upper address.
REQ-017 addr_req_common_side_dram  out  9  head address [8:0].
REQ-018 lane_from_cache_to_dram_side_dram  out  128  head victim data.
REQ-019 dram_controller_entry_dirty_side_dram  out  1  head dirty flag.
REQ-020 dram_controller_req_read_pulse_side_dram  out  1  single-cycle request pulse.
REQ-021 dram_controller_ack_read_pulse_side_dram  in  1  single-cycle completion pulse.
REQ-022 lane_from_dram_to_cache_side_dram  in  128  fetched data, valid in the ack cycle.
REQ-023 err_timeout, err_spurious_ack  out  1 each  sticky error flags.

Function
REQ-024 Request accepted when req_valid && req_ready; all request fields are written into a circular FIFO at the tail.
REQ-025 req_ready is registered: deasserts in the cycle after the accept that fills the queue; no bypass when a pop and a push occur while full.
REQ-026 FSM states: IDLE, ISSUE, WAIT_ACK.
REQ-027 IDLE -> ISSUE when the queue is non-empty and (rsp_valid==0 or rsp_ready==1).
REQ-028 In ISSUE the request pulse is 1 for exactly one cycle; next state WAIT_ACK.
REQ-029 WAIT_ACK -> IDLE on ack: rsp_lane <= lane_from_dram_to_cache_side_dram, rsp_addr <= head address, rsp_valid <= 1, head popped, all in the same edge.
REQ-030 DRAM-side address, lane and dirty outputs are registered copies of the queue head; they do not change from the ISSUE cycle through the ack cycle inclusive.
REQ-031 Accepting a request into an empty queue in cycle N produces the pulse in cycle N+2; rsp_valid rises in the cycle after ack.
REQ-032 rsp_valid clears on rsp_valid && rsp_ready unless a new ack loads it in the same edge, in which case it stays 1 with the new data.
REQ-033 Ack in IDLE or ISSUE is ignored and sets err_spurious_ack.
REQ-034 The WAIT_ACK counter is 10 bits, saturating, and clears on entry; reaching TIMEOUT_CYCLES sets err_timeout while the FSM keeps waiting without reissue.
REQ-035 Queue pointers wrap modulo QUEUE_DEPTH; the count is log2(QUEUE_DEPTH)+1 bits.

Reset
REQ-036 Reset assertion returns the FSM to IDLE and empties the queue.
REQ-037 On reset: all outputs 0, req_ready 0, and req_ready 1 on the first clock after deassertion.
REQ-038 Reset mid-WAIT_ACK discards the request; a later ack is flagged spurious.

Structure
REQ-039 A shared package holds the request struct (addr_read 22, write_upper 13, dirty 1, lane 128), the FSM state enum, and the 22/13/9/128 width constants.
REQ-040 The queue is a sub-module dram_req_fifo, parameterised by depth and payload type; the FSM and response register are in the top.

Verification
REQ-041 Single clean miss: addr 22'h12345, dirty 0, ack 6 cycles after the pulse with lane 128'hA5...A5 -> rsp_valid with that lane and addr 22'h12345; exactly one pulse.
REQ-042 Dirty victim: write_upper 13'h1ABC, lane 128'h0123...EF -> DRAM-side outputs hold these values from ISSUE through ack; common equals addr[8:0].
REQ-043 Back-to-back: 3 requests with QUEUE_DEPTH 2 -> req_ready low after 2 accepts; responses return in order; the second pulse does not occur while rsp_valid=1 and rsp_ready=0.
REQ-044 Backpressure: rsp_ready held 0 for 20 cycles -> no new pulse; rsp data is stable; issue resumes the cycle after the handshake.
REQ-045 Fault cases: no ack for 1023 cycles -> err_timeout=1; ack pulse in IDLE -> err_spurious_ack=1 with no rsp_valid.
REQ-046 Async reset asserted mid-WAIT_ACK -> outputs 0 immediately; a late ack sets err_spurious_ack only.

Source files
------------

// File: rtl/dram_miss_sequencer_pkg.sv
// Shared definitions for the DRAM miss sequencer.
// Holds the width constants, the queued request payload and the FSM state
// encoding. The top and the request FIFO both import it.
package dram_miss_sequencer_pkg;

  localparam int ADDR_W   = 22;  // cache line address
  localparam int UPPER_W  = 13;  // address bits [21:9]
  localparam int COMMON_W = 9;   // address bits [8:0], shared by read and victim
  localparam int LANE_W   = 128; // one cache line
  localparam int WAIT_W   = 10;  // WAIT_ACK cycle counter

  typedef struct packed {
    logic [ADDR_W-1:0]  addr_read;
    logic [UPPER_W-1:0] write_upper;
    logic               dirty;
    logic [LANE_W-1:0]  lane;
  } miss_req_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } seq_state_e;

endpackage

// File: rtl/dram_req_fifo.sv
// Circular request FIFO for the miss sequencer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the queue)
//   push        - write push_data at the tail (caller only pushes when ready)
//   push_data   - payload of type T
//   pop         - discard the head entry
//   head        - current head entry (valid when !empty)
//   empty       - queue holds no entries
//   ready       - registered "not full"; 0 in reset, 1 on the first clock after
module dram_req_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !do_pop)
      count_next = count + 1'b1;
    else if (!push && do_pop)
      count_next = count - 1'b1;
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // Looking at count_next makes ready fall right after the filling accept.
      ready <= (count_next != FULL_CNT);
    end
  end

endmodule

// File: rtl/dram_miss_sequencer.sv
// Sequences cache-miss requests to a DRAM controller one at a time.
// Ports:
//   main_clk, main_rst_n            - clock, async active-low reset
//   req_*                           - miss request (valid/ready), queued
//   rsp_*                           - fetched line back to the cache (valid/ready)
//   *_side_dram                     - registered copy of the queue head plus a
//                                     one-cycle request pulse / ack pulse pair
//   err_timeout, err_spurious_ack   - sticky error flags
module dram_miss_sequencer
  import dram_miss_sequencer_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                main_clk,
  input  logic                main_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr_read,
  input  logic [UPPER_W-1:0]  req_addr_write_upper,
  input  logic                req_dirty,
  input  logic [LANE_W-1:0]   req_lane_write,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ADDR_W-1:0]   rsp_addr,
  output logic [LANE_W-1:0]   rsp_lane,
  output logic [UPPER_W-1:0]  addr_req_read_dram_side_dram,
  output logic [UPPER_W-1:0]  addr_req_write_dram_side_dram,
  output logic [COMMON_W-1:0] addr_req_common_side_dram,
  output logic [LANE_W-1:0]   lane_from_cache_to_dram_side_dram,
  output logic                dram_controller_entry_dirty_side_dram,
  output logic                dram_controller_req_read_pulse_side_dram,
  input  logic                dram_controller_ack_read_pulse_side_dram,
  input  logic [LANE_W-1:0]   lane_from_dram_to_cache_side_dram,
  output logic                err_timeout,
  output logic                err_spurious_ack
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);

  seq_state_e        state;
  seq_state_e        state_next;
  miss_req_t         push_data;
  miss_req_t         head;
  logic              fifo_empty;
  logic              fifo_push;
  logic              ack;
  logic              load_head;
  logic              complete;
  logic              spurious;
  logic              req_pulse;
  logic [WAIT_W-1:0] wait_cnt;

  assign ack       = dram_controller_ack_read_pulse_side_dram;
  assign fifo_push = req_valid && req_ready;

  always_comb begin
    push_data             = '0;
    push_data.addr_read   = req_addr_read;
    push_data.write_upper = req_addr_write_upper;
    push_data.dirty       = req_dirty;
    push_data.lane        = req_lane_write;
  end

  dram_req_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (miss_req_t)
  ) u_fifo (
    .clk       (main_clk),
    .rst_n     (main_rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (complete),
    .head      (head),
    .empty     (fifo_empty),
    .ready     (req_ready)
  );

  // FSM state register
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // FSM next state: only start a fetch when the response slot is free or
  // is being drained this cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (!fifo_empty && (!rsp_valid || rsp_ready)) state_next = ST_ISSUE;
      ST_ISSUE:    state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_pulse = 1'b0;
    load_head = 1'b0;
    complete  = 1'b0;
    spurious  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_head = (state_next == ST_ISSUE);
        spurious  = ack;
      end
      ST_ISSUE: begin
        req_pulse = 1'b1;
        spurious  = ack;
      end
      ST_WAIT_ACK: complete = ack;
      default: ;
    endcase
  end

  assign dram_controller_req_read_pulse_side_dram = req_pulse;

  // DRAM-side copy of the head: captured on the way into ISSUE and frozen
  // until the next issue, so it is steady through the ack cycle.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      addr_req_read_dram_side_dram          <= '0;
      addr_req_write_dram_side_dram         <= '0;
      addr_req_common_side_dram             <= '0;
      lane_from_cache_to_dram_side_dram     <= '0;
      dram_controller_entry_dirty_side_dram <= 1'b0;
    end else if (load_head) begin
      addr_req_read_dram_side_dram          <= head.addr_read[ADDR_W-1:COMMON_W];
      addr_req_write_dram_side_dram         <= head.write_upper;
      addr_req_common_side_dram             <= head.addr_read[COMMON_W-1:0];
      lane_from_cache_to_dram_side_dram     <= head.lane;
      dram_controller_entry_dirty_side_dram <= head.dirty;
    end
  end

  // Response register; a fresh load wins over the drain handshake.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_lane  <= '0;
    end else if (complete) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= head.addr_read;
      rsp_lane  <= lane_from_dram_to_cache_side_dram;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // WAIT_ACK watchdog: flags only, the FSM keeps waiting without reissue.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      wait_cnt         <= '0;
      err_timeout      <= 1'b0;
      err_spurious_ack <= 1'b0;
    end else begin
      if (state == ST_ISSUE)
        wait_cnt <= '0;
      else if (state == ST_WAIT_ACK && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_WAIT_ACK && wait_cnt >= TIMEOUT_LIM)
        err_timeout <= 1'b1;
      if (spurious)
        err_spurious_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_miss_sequencer.sv
module tb_dram_miss_sequencer;

  logic         main_clk = 1'b0;
  logic         main_rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [21:0]  req_addr_read = '0;
  logic [12:0]  req_addr_write_upper = '0;
  logic         req_dirty = 1'b0;
  logic [127:0] req_lane_write = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [21:0]  rsp_addr;
  logic [127:0] rsp_lane;
  logic [12:0]  addr_rd;
  logic [12:0]  addr_wr;
  logic [8:0]   addr_common;
  logic [127:0] lane_out;
  logic         dirty_out;
  logic         pulse;
  logic         ack = 1'b0;
  logic [127:0] lane_in = '0;
  logic         err_timeout;
  logic         err_spurious_ack;

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_cnt = 0;

  localparam logic [21:0]  A_ADDR = 22'h00A01;
  localparam logic [21:0]  B_ADDR = 22'h1F3C2;
  localparam logic [21:0]  C_ADDR = 22'h20000;
  localparam logic [21:0]  D_ADDR = 22'h3FFFF;
  localparam logic [127:0] LA = {4{32'hAAAA0001}};
  localparam logic [127:0] LB = {4{32'hBBBB0002}};
  localparam logic [127:0] LC = {4{32'hCCCC0003}};

  dram_miss_sequencer #(
    .QUEUE_DEPTH    (2),
    .TIMEOUT_CYCLES (1023)
  ) dut (
    .main_clk                                 (main_clk),
    .main_rst_n                               (main_rst_n),
    .req_valid                                (req_valid),
    .req_ready                                (req_ready),
    .req_addr_read                            (req_addr_read),
    .req_addr_write_upper                     (req_addr_write_upper),
    .req_dirty                                (req_dirty),
    .req_lane_write                           (req_lane_write),
    .rsp_valid                                (rsp_valid),
    .rsp_ready                                (rsp_ready),
    .rsp_addr                                 (rsp_addr),
    .rsp_lane                                 (rsp_lane),
    .addr_req_read_dram_side_dram             (addr_rd),
    .addr_req_write_dram_side_dram            (addr_wr),
    .addr_req_common_side_dram                (addr_common),
    .lane_from_cache_to_dram_side_dram        (lane_out),
    .dram_controller_entry_dirty_side_dram    (dirty_out),
    .dram_controller_req_read_pulse_side_dram (pulse),
    .dram_controller_ack_read_pulse_side_dram (ack),
    .lane_from_dram_to_cache_side_dram        (lane_in),
    .err_timeout                              (err_timeout),
    .err_spurious_ack                         (err_spurious_ack)
  );

  always #5 main_clk = ~main_clk;

  always @(posedge main_clk) if (pulse) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic drive_req(input logic [21:0] a, input logic [12:0] wu, input logic d,
                           input logic [127:0] l);
    req_valid            = 1'b1;
    req_addr_read        = a;
    req_addr_write_upper = wu;
    req_dirty            = d;
    req_lane_write       = l;
  endtask

  task automatic do_ack(input logic [127:0] l);
    ack     = 1'b1;
    lane_in = l;
    step();
    ack     = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rdy"}, 128'(req_ready), 128'd0);
    check_eq({tag, "_rspv"}, 128'(rsp_valid), 128'd0);
    check_eq({tag, "_pulse"}, 128'(pulse), 128'd0);
    check_eq({tag, "_dram"}, {addr_rd, addr_wr, addr_common, dirty_out}, 128'd0);
    check_eq({tag, "_rsp"}, {rsp_addr, lane_out[63:0]}, 128'd0);
    check_eq({tag, "_err"}, {err_timeout, err_spurious_ack}, 128'd0);
  endtask

  initial begin
    int p0;

    // ---------------- reset ----------------
    step();
    step();
    check_outputs_zero("reset");
    main_rst_n = 1'b1;
    step();
    check_eq("rdy_after_reset", 128'(req_ready), 128'd1);

    // ---------------- single clean miss ----------------
    drive_req(22'h12345, 13'h0, 1'b0, 128'h0);
    p0 = pulse_cnt;
    step();                     // accepted at previous edge
    req_valid = 1'b0;
    check_eq("t1_no_pulse_n1", 128'(pulse), 128'd0);
    step();
    check_eq("t1_pulse_n2", 128'(pulse), 128'd1);
    check_eq("t1_dram_rd", 128'(addr_rd), 128'h091);
    check_eq("t1_dram_common", 128'(addr_common), 128'h145);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t1_wait_pulse", 128'(pulse), 128'd0);
    end
    step();                     // 6 cycles after pulse
    do_ack({16{8'hA5}});
    check_eq("t1_rspv", 128'(rsp_valid), 128'd1);
    check_eq("t1_rsp_lane", rsp_lane, {16{8'hA5}});
    check_eq("t1_rsp_addr", 128'(rsp_addr), 128'h12345);
    check_eq("t1_one_pulse", 128'(pulse_cnt - p0), 128'd1);
    rsp_ready = 1'b1;
    step();
    check_eq("t1_rspv_clr", 128'(rsp_valid), 128'd0);

    // ---------------- dirty victim ----------------
    drive_req(22'h2ABCD, 13'h1ABC, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF);
    step();
    req_valid = 1'b0;
    req_addr_write_upper = '0;
    req_lane_write = '0;
    step();
    check_eq("t2_pulse", 128'(pulse), 128'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_rd", 128'(addr_rd), 128'h155);
      check_eq("t2_wr", 128'(addr_wr), 128'h1ABC);
      check_eq("t2_common", 128'(addr_common), 128'h1CD);
      check_eq("t2_dirty", 128'(dirty_out), 128'd1);
      check_eq("t2_lane", lane_out, 128'h0123456789ABCDEF0123456789ABCDEF);
      if (i < 3) step();
    end
    do_ack(LC);
    check_eq("t2_rsp_addr", 128'(rsp_addr), 128'h2ABCD);
    check_eq("t2_rsp_lane", rsp_lane, LC);
    check_eq("t2_ack_wr_held", 128'(addr_wr), 128'h1ABC);
    step();
    check_eq("t2_rspv_clr", 128'(rsp_valid), 128'd0);

    // ---------------- back-to-back + backpressure ----------------
    rsp_ready = 1'b0;
    p0 = pulse_cnt;
    drive_req(A_ADDR, 13'h0001, 1'b0, 128'h1);
    step();
    check_eq("t3_rdy_after1", 128'(req_ready), 128'd1);
    drive_req(B_ADDR, 13'h0002, 1'b0, 128'h2);
    step();
    check_eq("t3_rdy_full", 128'(req_ready), 128'd0);
    check_eq("t3_pulse_a", 128'(pulse), 128'd1);
    check_eq("t3_dram_a", 128'({addr_rd, addr_common}), 128'(A_ADDR));
    drive_req(C_ADDR, 13'h0003, 1'b0, 128'h3);
    step();
    check_eq("t3_c_held_off", 128'(req_ready), 128'd0);
    step();
    step();
    do_ack(LA);
    check_eq("t3_rsp_a", 128'(rsp_addr), 128'(A_ADDR));
    check_eq("t3_rsp_lane_a", rsp_lane, LA);
    check_eq("t3_rdy_after_pop", 128'(req_ready), 128'd1);
    step();                     // C accepted at this edge
    req_valid = 1'b0;
    check_eq("t3_rdy_full2", 128'(req_ready), 128'd0);
    for (int i = 0; i < 20; i++) begin
      check_eq("t4_bp_pulse", 128'(pulse), 128'd0);
      check_eq("t4_bp_rspv", 128'(rsp_valid), 128'd1);
      check_eq("t4_bp_lane", rsp_lane, LA);
      step();
    end
    rsp_ready = 1'b1;
    step();                     // handshake edge
    check_eq("t4_rspv_drained", 128'(rsp_valid), 128'd0);
    check_eq("t4_resume_pulse_b", 128'(pulse), 128'd1);
    check_eq("t3_dram_b", 128'({addr_rd, addr_common}), 128'(B_ADDR));
    rsp_ready = 1'b0;
    step();
    step();
    do_ack(LB);
    check_eq("t3_rsp_b", 128'(rsp_addr), 128'(B_ADDR));
    check_eq("t3_rsp_lane_b", rsp_lane, LB);
    rsp_ready = 1'b1;
    step();
    check_eq("t3_pulse_c", 128'(pulse), 128'd1);
    check_eq("t3_dram_c", 128'({addr_rd, addr_common}), 128'(C_ADDR));
    step();
    do_ack(LC);
    check_eq("t3_rsp_c", 128'(rsp_addr), 128'(C_ADDR));
    check_eq("t3_rsp_lane_c", rsp_lane, LC);
    step();
    check_eq("t3_rspv_clr", 128'(rsp_valid), 128'd0);
    check_eq("t3_pulse_total", 128'(pulse_cnt - p0), 128'd3);

    // ---------------- spurious ack in IDLE ----------------
    check_eq("t5_spur_before", 128'(err_spurious_ack), 128'd0);
    do_ack(LA);
    check_eq("t5_spur_set", 128'(err_spurious_ack), 128'd1);
    check_eq("t5_spur_no_rsp", 128'(rsp_valid), 128'd0);

    // ---------------- timeout ----------------
    p0 = pulse_cnt;
    drive_req(D_ADDR, 13'h1FFF, 1'b1, LB);
    step();
    req_valid = 1'b0;
    step();
    check_eq("t6_pulse", 128'(pulse), 128'd1);
    // First WAIT_ACK cycle has count 0; the flag appears 1024 cycles after it.
    for (int i = 0; i < 1000; i++) step();
    check_eq("t6_no_timeout_yet", 128'(err_timeout), 128'd0);
    for (int i = 0; i < 30; i++) step();
    check_eq("t6_timeout", 128'(err_timeout), 128'd1);
    check_eq("t6_no_reissue", 128'(pulse_cnt - p0), 128'd1);
    check_eq("t6_dram_held", 128'({addr_rd, addr_common}), 128'(D_ADDR));

    // ---------------- async reset mid-WAIT_ACK ----------------
    main_rst_n = 1'b0;
    #1;
    check_outputs_zero("t7_async_rst");
    step();
    main_rst_n = 1'b1;
    step();
    check_eq("t7_rdy_back", 128'(req_ready), 128'd1);
    do_ack(LA);
    check_eq("t7_late_spur", 128'(err_spurious_ack), 128'd1);
    check_eq("t7_late_no_timeout", 128'(err_timeout), 128'd0);
    check_eq("t7_late_no_rsp", 128'(rsp_valid), 128'd0);
    step();
    check_eq("t7_late_no_pulse", 128'(pulse), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
